// File: rtl/bsg_cover_pkg.sv
// Shared definitions for the coverage drain transmitter/receiver pair.
// Holds the els/len field width, the receiver state encoding and a ceiling-divide helper.
package bsg_cover_pkg;

    localparam int cover_len_width_gp = 8;

    typedef enum logic [0:0] {
        e_cover_rx_recv = 1'b0,
        e_cover_rx_emit = 1'b1
    } cover_rx_state_e;

    function automatic int cover_cdiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up together load 1.
// The reset value is a parameter so a counter can start from a known preload.
module bsg_counter_clear_up #(
    parameter int                 width_p    = 8,
    parameter logic [width_p-1:0] init_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_o <= init_val_p;
        else if (clear_i)
            count_o <= width_p'(up_i);
        else if (up_i)
            count_o <= count_o + width_p'(1);
    end

endmodule

// File: rtl/bsg_cover_rx_sipo.sv
// Serial-in parallel-out word assembler for the coverage receiver.
// The first word of an entry clears the register, so earlier words end up most significant.
module bsg_cover_rx_sipo
    import bsg_cover_pkg::*;
#(
    parameter int in_width_p = 32,
    parameter int max_len_p  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              shift,
    input  logic [in_width_p-1:0]             word,
    input  logic [cover_len_width_gp-1:0]     len,
    output logic [max_len_p*in_width_p-1:0]   sr,
    output logic                              first,
    output logic                              entry_done
);

    localparam int sr_width_lp = max_len_p * in_width_p;

    logic [cover_len_width_gp-1:0] cnt;

    assign first      = (cnt == '0);
    assign entry_done = shift & (cnt == len - cover_len_width_gp'(1));

    bsg_counter_clear_up #(
        .width_p   (cover_len_width_gp)
    ) word_ctr (
        .clk_i     (clk),
        .reset_i   (reset),
        .clear_i   (entry_done),
        .up_i      (shift & ~entry_done),
        .count_o   (cnt)
    );

    generate
        if (max_len_p == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (reset)
                    sr <= '0;
                else if (shift)
                    sr <= word;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (reset)
                    sr <= '0;
                else if (shift)
                    sr <= first ? {{(sr_width_lp-in_width_p){1'b0}}, word}
                                : {sr[sr_width_lp-in_width_p-1:0], word};
            end
        end
    endgenerate

endmodule

// File: rtl/bsg_cover_rx.sv
// Coverage drain receiver: reassembles len-word serial transfers into entries,
// checks burst framing, and counts completed bursts.
module bsg_cover_rx
    import bsg_cover_pkg::*;
#(
    parameter int          width_p          = 64,
    parameter int          in_width_p       = 32,
    parameter int          max_len_p        = cover_cdiv(width_p, in_width_p),
    parameter logic [31:0] burst_cnt_init_p = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [7:0]            els_i,
    input  logic [7:0]            len_i,
    input  logic                  v_i,
    output logic                  ready_o,
    input  logic                  last_i,
    input  logic [in_width_p-1:0] data_i,
    output logic                  v_o,
    input  logic                  ready_i,
    output logic [width_p-1:0]    data_o,
    output logic                  burst_done_o,
    output logic [31:0]           burst_cnt_o,
    output logic                  err_o
);

    localparam int                            sr_width_lp = max_len_p * in_width_p;
    localparam logic [cover_len_width_gp-1:0] max_len_lp  = cover_len_width_gp'(max_len_p);

    cover_rx_state_e               state_r;
    logic                          last_seen_r;
    logic [cover_len_width_gp-1:0] len_r, els_r, ent_cnt, ent_next, len_eff;
    logic [sr_width_lp-1:0]        sr;
    logic accept, xfer, word_first, burst_first, entry_done;
    logic len_bad, els_bad, ent_hit, burst_end;

    assign ready_o     = (state_r == e_cover_rx_recv) & ~reset_i;
    assign accept      = v_i & ready_o;
    assign burst_first = word_first & (ent_cnt == '0);

    // The first word of a burst must use the live len_i, since len_r is not latched yet.
    assign len_bad = (len_i == '0) | (len_i > max_len_lp);
    assign els_bad = (els_i == '0);
    assign len_eff = burst_first ? (len_bad ? max_len_lp : len_i) : len_r;

    bsg_cover_rx_sipo #(
        .in_width_p (in_width_p),
        .max_len_p  (max_len_p)
    ) sipo (
        .clk        (clk_i),
        .reset      (reset_i),
        .shift      (accept),
        .word       (data_i),
        .len        (len_eff),
        .sr         (sr),
        .first      (word_first),
        .entry_done (entry_done)
    );

    assign v_o          = (state_r == e_cover_rx_emit);
    assign data_o       = sr[width_p-1:0];
    assign xfer         = v_o & ready_i;
    assign ent_next     = ent_cnt + cover_len_width_gp'(1);
    assign ent_hit      = (ent_next == els_r);
    assign burst_done_o = xfer & last_seen_r;
    assign burst_end    = xfer & (last_seen_r | ent_hit);

    bsg_counter_clear_up #(
        .width_p   (cover_len_width_gp)
    ) ent_ctr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (burst_end),
        .up_i      (xfer & ~burst_end),
        .count_o   (ent_cnt)
    );

    bsg_counter_clear_up #(
        .width_p    (32),
        .init_val_p (burst_cnt_init_p)
    ) burst_ctr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (1'b0),
        .up_i       (burst_done_o),
        .count_o    (burst_cnt_o)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= e_cover_rx_recv;
            last_seen_r <= 1'b0;
            len_r       <= '0;
            els_r       <= '0;
        end else begin
            if (accept & burst_first) begin
                len_r <= len_eff;
                els_r <= els_bad ? cover_len_width_gp'(1) : els_i;
            end
            case (state_r)
                e_cover_rx_recv: if (entry_done) begin
                    state_r     <= e_cover_rx_emit;
                    last_seen_r <= last_i;
                end
                default: if (ready_i) state_r <= e_cover_rx_recv;
            endcase
        end
    end

    // Sticky: bad config, early last, or burst length disagreeing with els.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            err_o <= 1'b0;
        else if ((accept & burst_first & (len_bad | els_bad))
               | (accept & last_i & ~entry_done)
               | (xfer & (last_seen_r ^ ent_hit)))
            err_o <= 1'b1;
    end

endmodule
